// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the fetch PC, keeps at most one
// memory request outstanding, buffers the returned word for decode, and handles
// redirects (branch/trap/mret) at any point, including orphaned responses.
//
// Handshakes:
//   memory side : a request is accepted in a cycle where o_mem_req && i_mem_gnt;
//                 its single response arrives with i_mem_rvalid, at least one
//                 cycle later. No new request is issued until that response
//                 has been seen.
//   decode side : an instruction transfers in a cycle where o_inst_valid &&
//                 i_inst_ready; o_inst/o_inst_pc stay stable while valid is
//                 high and ready is low. A redirect in the same cycle wins and
//                 the transfer does not happen.
module fetch_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_addr,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_gnt,
   input  logic            i_mem_rvalid,
   input  logic [31:0]     i_mem_rdata,
   output logic            o_inst_valid,
   input  logic            i_inst_ready,
   output logic [31:0]     o_inst,
   output logic [XLEN-1:0] o_inst_pc,
   output logic [XLEN-1:0] o_inst_pc_4,
   output logic            o_t_inst_addr_misaligned,
   output logic [2:0]      o_dbg_state
);

   typedef enum logic [2:0] {
      ST_REQ   = 3'd0,
      ST_WAIT  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4,
      ST_IDLE  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_pc_q;
   logic [31:0]     buf_inst_q;
   logic            buf_load;

   // Entering a new fetch address: misaligned targets never reach memory.
   function automatic state_t entry_state(input logic [XLEN-1:0] a);
      return (a[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
   endfunction

   // Next-state, next-pc and output decode for the fetch sequencer.
   always_comb begin
      state_d                  = state_q;
      pc_d                     = pc_q;
      buf_load                 = 1'b0;
      o_mem_req                = 1'b0;
      o_mem_addr               = pc_q;
      o_inst_valid             = 1'b0;
      o_inst                   = NOP_INST;
      o_inst_pc                = buf_pc_q;
      o_t_inst_addr_misaligned = 1'b0;

      case (state_q)
         ST_REQ: begin
            // A redirect withdraws the request so the stale address is never granted.
            o_mem_req = !i_redirect && i_rst_n;
            if (i_redirect) begin
               pc_d    = i_redirect_addr;
               state_d = entry_state(i_redirect_addr);
            end else if (i_mem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_redirect) begin
               pc_d = i_redirect_addr;
               // Response already here: drop it and move on; otherwise wait it out.
               state_d = i_mem_rvalid ? entry_state(i_redirect_addr) : ST_DRAIN;
            end else if (i_mem_rvalid) begin
               buf_load = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            if (i_redirect) begin
               pc_d = i_redirect_addr;
            end
            if (i_mem_rvalid) begin
               // The orphan is discarded; the newest target decides fault vs fetch.
               state_d = entry_state(i_redirect ? i_redirect_addr : pc_q);
            end
         end
         ST_HOLD: begin
            o_inst_valid             = 1'b1;
            o_inst                   = buf_inst_q;
            o_inst_pc                = buf_pc_q;
            o_t_inst_addr_misaligned = (buf_pc_q[1:0] != 2'b00);
            if (i_redirect) begin
               pc_d    = i_redirect_addr;
               state_d = entry_state(i_redirect_addr);
            end else if (i_inst_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = ST_REQ;
            end
         end
         ST_FAULT: begin
            o_inst_valid             = 1'b1;
            o_inst                   = NOP_INST;
            o_inst_pc                = pc_q;
            o_t_inst_addr_misaligned = (pc_q[1:0] != 2'b00);
            if (i_redirect) begin
               pc_d    = i_redirect_addr;
               state_d = entry_state(i_redirect_addr);
            end else if (i_inst_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // Parked until the trap handler redirects us.
            if (i_redirect) begin
               pc_d    = i_redirect_addr;
               state_d = entry_state(i_redirect_addr);
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   assign o_inst_pc_4 = o_inst_pc + XLEN'(4);
   assign o_dbg_state = state_q;

   // State and fetch PC registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Output buffer: captures the returned word together with the PC it was fetched from.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buf_inst_q <= NOP_INST;
         buf_pc_q   <= RESET_VECTOR;
      end else if (buf_load) begin
         buf_inst_q <= i_mem_rdata;
         buf_pc_q   <= pc_q;
      end
   end

endmodule
